// File: rtl/muldiv_iter_if.sv
// muldiv_iter_if -- EX-stage request/response bundle for the muldiv_iter unit.
//
// Signals:
//   Md_op    [3:0]    operation code (DIV, DIVU, MFHI, MFLO, MTHI, MTLO, MUL, MULT, MULTU, else NOP)
//   Rs_in    [WIDTH]  operand A / dividend / MTHI-MTLO source
//   Rt_in    [WIDTH]  operand B / divisor
//   Md_kill           flush of the in-flight operation
//   Res_out  [WIDTH]  result for MUL/MFHI/MFLO, 0 otherwise
//   Md_stall          pipeline hold request
// Modports: master (pipeline side), slave (muldiv_iter side).
interface muldiv_iter_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       Md_op;
    logic [WIDTH-1:0] Rs_in;
    logic [WIDTH-1:0] Rt_in;
    logic             Md_kill;
    logic [WIDTH-1:0] Res_out;
    logic             Md_stall;

    modport master (
        output Md_op, Rs_in, Rt_in, Md_kill,
        input  Res_out, Md_stall
    );

    modport slave (
        input  Md_op, Rs_in, Rt_in, Md_kill,
        output Res_out, Md_stall
    );
endinterface

// File: rtl/muldiv_iter.sv
// muldiv_iter -- iterative multiply/divide unit with architectural HI/LO.
//
// Multiplies complete after MUL_CYCLES stall cycles. Divides use a radix-2
// restoring divider (one quotient bit per cycle, WIDTH+1 stall cycles).
// MFHI/MFLO/MTHI/MTLO complete without stalling.
//
// Ports:
//   Clk    system clock, rising edge
//   Rst_n  asynchronous active-low reset
//   bus    muldiv_iter_if.slave (Md_op, Rs_in, Rt_in, Md_kill -> Res_out, Md_stall)
//
// Optional build macro: MULDIV_EARLY_DIV_EN -- skips the dividend's leading
// zeros so a divide takes WIDTH-k+1 stall cycles (minimum 1). Results are
// identical to the default build.
module muldiv_iter #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 6
) (
    input  logic         Clk,
    input  logic         Rst_n,
    muldiv_iter_if.slave bus
);
    localparam logic [3:0] OP_DIV   = 4'b0001;
    localparam logic [3:0] OP_DIVU  = 4'b0010;
    localparam logic [3:0] OP_MFHI  = 4'b0011;
    localparam logic [3:0] OP_MFLO  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;
    localparam logic [3:0] OP_MUL   = 4'b0111;
    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;

    typedef enum logic [1:0] {IDLE, MUL_BUSY, DIV_BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] mres_q, mres_d;
    logic [WIDTH-1:0] opa_q, opa_d;   // multiplicand, or dividend/quotient shift register
    logic [WIDTH-1:0] opb_q, opb_d;   // multiplier magnitude, or divisor magnitude
    logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder, always < divisor
    logic [3:0]       op_q, op_d;
    logic             neg_q, neg_d;   // sign of product / quotient
    logic             rneg_q, rneg_d; // sign of remainder (follows dividend)
    logic             div0_q, div0_d;

    logic             stall_c;
    logic [WIDTH-1:0] res_c;

    function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
        return n ? -v : v;
    endfunction

    // Operand conditioning: signed ops work on magnitudes, sign restored at write.
    logic             signed_op, a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;

    assign signed_op = (bus.Md_op == OP_DIV) || (bus.Md_op == OP_MUL) || (bus.Md_op == OP_MULT);
    assign a_neg     = signed_op & bus.Rs_in[WIDTH-1];
    assign b_neg     = signed_op & bus.Rt_in[WIDTH-1];
    assign a_abs     = neg_if(a_neg, bus.Rs_in);
    assign b_abs     = neg_if(b_neg, bus.Rt_in);

    // One restoring step. rem_sh < 2*divisor, so bit WIDTH of diff is a valid sign.
    logic [WIDTH:0]   rem_sh, diff;
    logic [WIDTH-1:0] rem_nx, quo_nx;
    logic             step_ok;

    assign rem_sh  = {rem_q, opa_q[WIDTH-1]};
    assign diff    = rem_sh - {1'b0, opb_q};
    assign step_ok = ~diff[WIDTH];
    assign rem_nx  = step_ok ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_nx  = {opa_q[WIDTH-2:0], step_ok};

    logic [2*WIDTH-1:0] prod, prod_s;
    assign prod   = {{WIDTH{1'b0}}, opa_q} * {{WIDTH{1'b0}}, opb_q};
    assign prod_s = neg_q ? -prod : prod;

`ifdef MULDIV_EARLY_DIV_EN
    function automatic int lzc(input logic [WIDTH-1:0] v);
        int n;
        n = WIDTH;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) n = WIDTH - 1 - i;
        end
        return n;
    endfunction

    int lead_z;
    assign lead_z = lzc(a_abs);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mres_d  = mres_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        rem_d   = rem_q;
        op_d    = op_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        div0_d  = div0_q;
        stall_c = 1'b0;
        res_c   = '0;

        case (state_q)
            IDLE: begin
                case (bus.Md_op)
                    OP_MFHI: res_c = hi_q;
                    OP_MFLO: res_c = lo_q;
                    OP_MTHI: if (!bus.Md_kill) hi_d = bus.Rs_in;
                    OP_MTLO: if (!bus.Md_kill) lo_d = bus.Rs_in;
                    OP_MUL, OP_MULT, OP_MULTU: begin
                        if (!bus.Md_kill) begin
                            stall_c = 1'b1;
                            state_d = MUL_BUSY;
                            cnt_d   = CNT_W'(MUL_CYCLES - 1);
                            opa_d   = a_abs;
                            opb_d   = b_abs;
                            neg_d   = a_neg ^ b_neg;
                            op_d    = bus.Md_op;
                        end
                    end
                    OP_DIV, OP_DIVU: begin
                        if (!bus.Md_kill) begin
                            stall_c = 1'b1;
                            opb_d   = b_abs;
                            neg_d   = a_neg ^ b_neg;
                            rneg_d  = a_neg;
                            div0_d  = (bus.Rt_in == '0);
                            rem_d   = '0;
                            op_d    = bus.Md_op;
`ifdef MULDIV_EARLY_DIV_EN
                            if (lead_z == WIDTH) begin
                                // Zero dividend: quotient and remainder are known now.
                                state_d = DONE;
                                lo_d    = (bus.Rt_in == '0) ? '1 : '0;
                                hi_d    = '0;
                            end else begin
                                state_d = DIV_BUSY;
                                opa_d   = a_abs << lead_z;
                                cnt_d   = CNT_W'(WIDTH - lead_z);
                            end
`else
                            state_d = DIV_BUSY;
                            opa_d   = a_abs;
                            cnt_d   = CNT_W'(WIDTH);
`endif
                        end
                    end
                    default: ;
                endcase
            end

            MUL_BUSY: begin
                if (bus.Md_kill) begin
                    state_d = IDLE;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = DONE;
                        if (op_q == OP_MUL) mres_d = prod_s[WIDTH-1:0];
                        else                {hi_d, lo_d} = prod_s;
                    end
                end
            end

            DIV_BUSY: begin
                if (bus.Md_kill) begin
                    state_d = IDLE;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);
                    rem_d   = rem_nx;
                    opa_d   = quo_nx;
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = DONE;
                        // With a zero divisor every step succeeds and the remainder
                        // ends as |dividend|, so HI still comes out as Rs_in.
                        lo_d    = div0_q ? '1 : neg_if(neg_q, quo_nx);
                        hi_d    = neg_if(rneg_q, rem_nx);
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
                if (op_q == OP_MUL) res_c = mres_q;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mres_q  <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            rem_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mres_q  <= mres_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            div0_q  <= div0_d;
        end
    end

    // Outputs are forced quiet while reset is asserted, regardless of Md_op.
    assign bus.Md_stall = stall_c & Rst_n;
    assign bus.Res_out  = Rst_n ? res_c : '0;

endmodule

// File: tb/tb_muldiv_iter.sv
module tb_muldiv_iter;
    localparam int W  = 32;
    localparam int MC = 4;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_DIV   = 4'b0001;
    localparam logic [3:0] OP_DIVU  = 4'b0010;
    localparam logic [3:0] OP_MFHI  = 4'b0011;
    localparam logic [3:0] OP_MFLO  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;
    localparam logic [3:0] OP_MUL   = 4'b0111;
    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;

    logic Clk = 1'b0;
    logic Rst_n;
    always #5 Clk = ~Clk;

    muldiv_iter_if #(.WIDTH(W)) bus ();

    muldiv_iter #(.WIDTH(W), .MUL_CYCLES(MC), .CNT_W(6)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] res;
        int          stall;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected stall for a divide with dividend magnitude mag.
    function automatic int div_stall(input logic [31:0] mag);
`ifdef MULDIV_EARLY_DIV_EN
        int k;
        k = 32;
        for (int i = 0; i < 32; i++) if (mag[i]) k = 31 - i;
        return (k == 32) ? 1 : 33 - k;
`else
        return (mag == 32'h0) ? W + 1 : W + 1;
`endif
    endfunction

    // Behavioural reference: plain 64-bit arithmetic on architectural HI/LO.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] hi, inout logic [31:0] lo,
                         output logic [31:0] res, output int st);
        longint          sa, sb, p;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        res = '0;
        st  = 0;
        case (op)
            OP_MUL:   begin p = sa * sb; res = p[31:0]; st = MC; end
            OP_MULT:  begin p = sa * sb; {hi, lo} = p; st = MC; end
            OP_MULTU: begin up = ua * ub; {hi, lo} = up; st = MC; end
            OP_DIV: begin
                if (b == 0) begin lo = '1; hi = a; end
                else begin p = sa / sb; lo = p[31:0]; p = sa % sb; hi = p[31:0]; end
                p  = (sa < 0) ? -sa : sa;
                st = div_stall(p[31:0]);
            end
            OP_DIVU: begin
                if (b == 0) begin lo = '1; hi = a; end
                else begin up = ua / ub; lo = up[31:0]; up = ua % ub; hi = up[31:0]; end
                st = div_stall(a);
            end
            OP_MTHI: hi = a;
            OP_MTLO: lo = a;
            OP_MFHI: res = hi;
            OP_MFLO: res = lo;
            default: ;
        endcase
    endtask

    // Issue one op, count stall cycles, capture Res_out in the first non-stall cycle.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int stalls, output logic [31:0] res);
        @(negedge Clk);
        bus.Md_op   = op;
        bus.Rs_in   = a;
        bus.Rt_in   = b;
        bus.Md_kill = 1'b0;
        #1;
        stalls = 0;
        while (bus.Md_stall === 1'b1 && stalls < 100) begin
            stalls++;
            @(negedge Clk);
            #1;
        end
        res = bus.Res_out;
        @(negedge Clk);
        bus.Md_op = OP_NOP;
    endtask

    task automatic read_hl(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int          st;
        logic [31:0] r;
        run_op(OP_MFHI, 32'h0, 32'h0, st, r);
        check({tag, " HI"}, r, exp_hi);
        check({tag, " MFHI stall"}, st, 0);
        run_op(OP_MFLO, 32'h0, 32'h0, st, r);
        check({tag, " LO"}, r, exp_lo);
        check({tag, " MFLO stall"}, st, 0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    vec_t vecs[10];

    initial begin
        int          st;
        int          exp_st;
        logic [31:0] r, m_hi, m_lo, m_res, a, b;
        logic [3:0]  op;
        logic [3:0]  rand_ops[7];

        vecs[0] = '{OP_MULT,  32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0,         MC};
        vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'h2,         32'h1,         32'hFFFF_FFFE, 32'h0,         MC};
        vecs[2] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        32'h0,         W + 1};
        vecs[3] = '{OP_DIV,   32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0,         W + 1};
        vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 32'h0,         W + 1};
        vecs[5] = '{OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 32'h0,         W + 1};
        vecs[6] = '{OP_MUL,   32'd3,         32'hFFFF_FFFC, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF4, MC};
        vecs[7] = '{OP_DIV,   32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 32'h0,         W + 1};
        vecs[8] = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'h0,         W + 1};
        vecs[9] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         32'h0,         MC};

        // Reset: outputs quiet even with a mul/MFHI presented.
        Rst_n       = 1'b0;
        bus.Md_op   = OP_MULT;
        bus.Rs_in   = 32'd1;
        bus.Rt_in   = 32'd1;
        bus.Md_kill = 1'b0;
        repeat (3) @(negedge Clk);
        #1;
        check("reset stall", bus.Md_stall, 1'b0);
        bus.Md_op = OP_MFHI;
        #1;
        check("reset res", bus.Res_out, 32'h0);
        @(negedge Clk);
        bus.Md_op = OP_NOP;
        Rst_n     = 1'b1;
        read_hl("after reset", 32'h0, 32'h0);

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            exp_st = vecs[i].stall;
`ifdef MULDIV_EARLY_DIV_EN
            if (vecs[i].op == OP_DIV || vecs[i].op == OP_DIVU) begin
                m_hi = 0; m_lo = 0;
                model(vecs[i].op, vecs[i].a, vecs[i].b, m_hi, m_lo, m_res, exp_st);
            end
`endif
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, st, r);
            check($sformatf("vec%0d stall", i), st, exp_st);
            check($sformatf("vec%0d res", i), r, vecs[i].res);
            read_hl($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo);
        end

        // MTHI, then MULT killed in its second stall cycle: HI/LO untouched.
        run_op(OP_MTHI, 32'h1234, 32'h0, st, r);
        check("mthi stall", st, 0);
        check("mthi res", r, 32'h0);
        @(negedge Clk);
        bus.Md_op = OP_MULT; bus.Rs_in = 32'd5; bus.Rt_in = 32'd6; bus.Md_kill = 1'b0;
        #1;
        check("kill cycle1 stall", bus.Md_stall, 1'b1);
        @(negedge Clk);
        bus.Md_kill = 1'b1;
        #1;
        check("kill drops stall", bus.Md_stall, 1'b0);
        @(negedge Clk);
        bus.Md_op = OP_NOP; bus.Md_kill = 1'b0;
        #1;
        check("after kill idle", bus.Md_stall, 1'b0);
        read_hl("after kill", 32'h1234, 32'h0);

        // MTLO immediately followed by MFLO.
        @(negedge Clk);
        bus.Md_op = OP_MTLO; bus.Rs_in = 32'hABCD;
        @(negedge Clk);
        bus.Md_op = OP_MFLO;
        #1;
        check("mtlo->mflo", bus.Res_out, 32'hABCD);
        check("mflo no stall", bus.Md_stall, 1'b0);

        // Kill in IDLE suppresses the start.
        @(negedge Clk);
        bus.Md_op = OP_DIVU; bus.Rs_in = 32'd9; bus.Rt_in = 32'd3; bus.Md_kill = 1'b1;
        #1;
        check("idle kill stall", bus.Md_stall, 1'b0);
        @(negedge Clk);
        bus.Md_op = OP_NOP; bus.Md_kill = 1'b0;
        #1;
        check("idle kill no start", bus.Md_stall, 1'b0);
        read_hl("idle kill", 32'h1234, 32'hABCD);

        // NOP code: no effect, Res_out 0.
        run_op(4'hF, 32'h55, 32'h66, st, r);
        check("nop stall", st, 0);
        check("nop res", r, 32'h0);
        read_hl("after nop", 32'h1234, 32'hABCD);

        // Reset pulsed mid-divide.
        @(negedge Clk);
        bus.Md_op = OP_DIV; bus.Rs_in = 32'd100; bus.Rt_in = 32'd3;
        repeat (5) @(negedge Clk);
        #1;
        check("mid-div stall", bus.Md_stall, 1'b1);
        #1;
        Rst_n = 1'b0;
        #1;
        check("mid-div reset stall", bus.Md_stall, 1'b0);
        @(negedge Clk);
        bus.Md_op = OP_NOP;
        Rst_n     = 1'b1;
        read_hl("mid-div reset", 32'h0, 32'h0);

        // Randomised ops against the reference model.
        rand_ops = '{OP_DIV, OP_DIVU, OP_MUL, OP_MULT, OP_MULTU, OP_MTHI, OP_MTLO};
        m_hi = 32'h0;
        m_lo = 32'h0;
        for (int i = 0; i < 40; i++) begin
            op = rand_ops[$urandom_range(0, 6)];
            a  = pick_operand();
            b  = pick_operand();
            model(op, a, b, m_hi, m_lo, m_res, exp_st);
            run_op(op, a, b, st, r);
            check($sformatf("rnd%0d op%0h %h,%h stall", i, op, a, b), st, exp_st);
            check($sformatf("rnd%0d op%0h %h,%h res", i, op, a, b), r, m_res);
            read_hl($sformatf("rnd%0d op%0h %h,%h", i, op, a, b), m_hi, m_lo);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
